// File: rtl/prmcu_uart_pkg.sv
// Shared UART receive-path constants and word type.
package prmcu_uart_pkg;

   localparam int unsigned UART_DATA_W   = 9;
   localparam int unsigned RX_FIFO_DEPTH = 16;

   typedef logic [UART_DATA_W-1:0] uart_word_t;

endpackage

// File: rtl/prmcu_uart_rx_fifo_if.sv
// Receiver-side and reader-side streams of the RX FIFO.
interface prmcu_uart_rx_fifo_if #(
   parameter int unsigned DATA_W = prmcu_uart_pkg::UART_DATA_W
);

   logic [DATA_W-1:0] in_dat_i;
   logic              in_vld_i;
   logic              in_rdy_o;
   logic [DATA_W-1:0] out_dat_o;
   logic              out_vld_o;
   logic              out_rdy_i;

   modport master (
      output in_dat_i, in_vld_i, out_rdy_i,
      input  in_rdy_o, out_dat_o, out_vld_o
   );

   modport slave (
      input  in_dat_i, in_vld_i, out_rdy_i,
      output in_rdy_o, out_dat_o, out_vld_o
   );

endinterface

// File: rtl/prmcu_fifo_mem.sv
// DEPTH x DATA_W register array: one synchronous write port, one combinational read port.
module prmcu_fifo_mem #(
   parameter  int unsigned DATA_W = 9,
   parameter  int unsigned DEPTH  = 16,
   localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/prmcu_uart_rx_fifo.sv
// UART receive FWFT FIFO: drops on full with sticky overrun, level and threshold interrupt.
module prmcu_uart_rx_fifo
   import prmcu_uart_pkg::*;
#(
   parameter  int unsigned DATA_W = UART_DATA_W,
   parameter  int unsigned DEPTH  = RX_FIFO_DEPTH,
   localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic                clk,
   input  logic                rst,
   prmcu_uart_rx_fifo_if.slave bus,
   input  logic                fifo_en_i,
   input  logic                flush_i,
   output logic [ADDR_W:0]     level_o,
   input  logic [ADDR_W:0]     threshold_i,
   output logic                thr_irq_o,
   output logic                full_o,
   output logic                empty_o,
   output logic                overrun_o,
   input  logic                overrun_clr_i
);

   logic [ADDR_W:0]   wr_ptr, rd_ptr, wr_nxt, rd_nxt, level_nxt;
   logic              full, nonempty, pop, push, drop;
   logic [DATA_W-1:0] rdata;

   always_comb begin
      nonempty = (wr_ptr != rd_ptr);
      full     = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                 (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
      pop      = nonempty && bus.out_rdy_i;
      // Flush overrides everything; a pop frees the slot for a same-cycle push when full.
      push     = !flush_i && bus.in_vld_i && fifo_en_i && (!full || pop);
      drop     = !flush_i && bus.in_vld_i && fifo_en_i && full && !pop;
      wr_nxt   = flush_i ? '0 : wr_ptr + {{ADDR_W{1'b0}}, push};
      rd_nxt   = flush_i ? '0 : rd_ptr + {{ADDR_W{1'b0}}, (pop && !flush_i)};
      level_nxt = wr_nxt - rd_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         thr_irq_o <= 1'b0;
         overrun_o <= 1'b0;
      end else begin
         wr_ptr    <= wr_nxt;
         rd_ptr    <= rd_nxt;
         thr_irq_o <= (threshold_i != '0) && (level_nxt >= threshold_i);
         if (flush_i)            overrun_o <= 1'b0;
         else if (drop)          overrun_o <= 1'b1;
         else if (overrun_clr_i) overrun_o <= 1'b0;
      end
   end

   prmcu_fifo_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_mem (
      .clk   (clk),
      .we    (push),
      .waddr (wr_ptr[ADDR_W-1:0]),
      .wdata (bus.in_dat_i),
      .raddr (rd_ptr[ADDR_W-1:0]),
      .rdata (rdata)
   );

   assign bus.out_dat_o = rdata;
   assign bus.out_vld_o = nonempty;
   assign bus.in_rdy_o  = fifo_en_i;
   assign level_o       = wr_ptr - rd_ptr;
   assign full_o        = full;
   assign empty_o       = !nonempty;

endmodule

// File: tb/tb_prmcu_uart_rx_fifo.sv
// Scoreboard bench for prmcu_uart_rx_fifo: directed fill/drain, overrun, threshold, flush, wrap and reset.
module tb_prmcu_uart_rx_fifo;
   import prmcu_uart_pkg::*;

   localparam int unsigned DEPTH = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       fifo_en, flush, ovr_clr;
   logic [4:0] level, threshold;
   logic       thr_irq, full, empty, overrun;

   int unsigned vectors    = 0;
   int unsigned miscompares = 0;
   uart_word_t  sb[$];
   uart_word_t  exp_word;
   logic        ovr_m = 1'b0;

   prmcu_uart_rx_fifo_if #(.DATA_W(UART_DATA_W)) bus ();

   prmcu_uart_rx_fifo #(
      .DATA_W (UART_DATA_W),
      .DEPTH  (DEPTH)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .bus           (bus),
      .fifo_en_i     (fifo_en),
      .flush_i       (flush),
      .level_o       (level),
      .threshold_i   (threshold),
      .thr_irq_o     (thr_irq),
      .full_o        (full),
      .empty_o       (empty),
      .overrun_o     (overrun),
      .overrun_clr_i (ovr_clr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Monitor: a pop happens on the next edge whenever valid & ready are seen here.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && !flush && bus.out_vld_o && bus.out_rdy_i) begin
            if (sb.size() == 0) begin
               chk("pop_unexpected", {31'd0, bus.out_vld_o}, 32'd0);
            end else begin
               exp_word = sb.pop_front();
               chk("pop_data", {23'd0, bus.out_dat_o}, {23'd0, exp_word});
            end
         end
      end
   end

   // One clock cycle of stimulus; expected contents are queued at issue time.
   task automatic cyc(input logic vld, input logic [8:0] dat, input logic rdy,
                      input logic fl = 1'b0, input logic clr = 1'b0);
      int unsigned s;
      logic d;
      s = sb.size();
      d = 1'b0;
      bus.in_vld_i  = vld;
      bus.in_dat_i  = dat;
      bus.out_rdy_i = rdy;
      flush         = fl;
      ovr_clr       = clr;
      if (fl) begin
         sb.delete();
         ovr_m = 1'b0;
      end else begin
         if (vld && fifo_en) begin
            if (s < DEPTH || rdy) sb.push_back(dat);
            else d = 1'b1;
         end
         if (d)        ovr_m = 1'b1;
         else if (clr) ovr_m = 1'b0;
      end
      @(posedge clk);
      #1;
      bus.in_vld_i = 1'b0;
      flush        = 1'b0;
      ovr_clr      = 1'b0;
      chk("level",   {27'd0, level},          sb.size());
      chk("empty",   {31'd0, empty},          {31'd0, (sb.size() == 0)});
      chk("full",    {31'd0, full},           {31'd0, (sb.size() == DEPTH)});
      chk("out_vld", {31'd0, bus.out_vld_o},  {31'd0, (sb.size() != 0)});
      chk("overrun", {31'd0, overrun},        {31'd0, ovr_m});
      chk("thr_irq", {31'd0, thr_irq},        {31'd0, (threshold != 0 && sb.size() >= threshold)});
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_level"},   {27'd0, level},         32'd0);
      chk({tag, "_out_vld"}, {31'd0, bus.out_vld_o}, 32'd0);
      chk({tag, "_empty"},   {31'd0, empty},         32'd1);
      chk({tag, "_full"},    {31'd0, full},          32'd0);
      chk({tag, "_thr_irq"}, {31'd0, thr_irq},       32'd0);
      chk({tag, "_overrun"}, {31'd0, overrun},       32'd0);
   endtask

   task automatic drain();
      for (int k = 0; k < 40 && sb.size() > 0; k++) cyc(1'b0, 9'h000, 1'b1);
      chk("drain_empty", {31'd0, empty}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned cnt;
      int unsigned k;
      fifo_en       = 1'b1;
      flush         = 1'b0;
      ovr_clr       = 1'b0;
      threshold     = 5'd0;
      bus.in_vld_i  = 1'b0;
      bus.in_dat_i  = '0;
      bus.out_rdy_i = 1'b0;
      #1 rst = 1'b1;
      #2 check_reset("reset");
      #9 rst = 1'b0;
      @(posedge clk);
      #1;

      // 1: fill and drain in order
      for (int i = 0; i < 16; i++) begin
         cyc(1'b1, 9'(i), 1'b0);
         if (i == 0) begin
            chk("t1_vld_1st", {31'd0, bus.out_vld_o}, 32'd1);
            chk("t1_dat_1st", {23'd0, bus.out_dat_o}, 32'h000);
         end
      end
      chk("t1_full",  {31'd0, full}, 32'd1);
      chk("t1_level", {27'd0, level}, 32'd16);
      drain();
      chk("t1_overrun", {31'd0, overrun}, 32'd0);

      // 2: overrun drops the word and leaves contents intact
      for (int i = 0; i < 16; i++) cyc(1'b1, 9'(9'h040 + i), 1'b0);
      cyc(1'b1, 9'h1AA, 1'b0);
      chk("t2_overrun", {31'd0, overrun}, 32'd1);
      chk("t2_level",   {27'd0, level},   32'd16);
      drain();
      chk("t2_overrun_held", {31'd0, overrun}, 32'd1);
      cyc(1'b0, 9'h000, 1'b0, 1'b0, 1'b1);
      chk("t2_overrun_clr", {31'd0, overrun}, 32'd0);

      // 3: push and pop together while full
      for (int i = 0; i < 16; i++) cyc(1'b1, 9'(9'h080 + i), 1'b0);
      cyc(1'b1, 9'h155, 1'b1);
      chk("t3_level",   {27'd0, level},   32'd16);
      chk("t3_overrun", {31'd0, overrun}, 32'd0);
      for (int i = 0; i < 15; i++) cyc(1'b0, 9'h000, 1'b1);
      chk("t3_last", {23'd0, bus.out_dat_o}, 32'h155);
      drain();

      // 4: threshold interrupt
      threshold = 5'd4;
      for (int i = 0; i < 4; i++) begin
         cyc(1'b1, 9'(9'h0A0 + i), 1'b0);
         chk("t4_irq", {31'd0, thr_irq}, (i == 3) ? 32'd1 : 32'd0);
      end
      cyc(1'b0, 9'h000, 1'b1);
      chk("t4_irq_drop", {31'd0, thr_irq}, 32'd0);
      threshold = 5'd0;
      for (int i = 0; i < 10; i++) cyc(1'b1, 9'(9'h0B0 + i), 1'b0);
      chk("t4_irq_off", {31'd0, thr_irq}, 32'd0);
      drain();

      // 5: flush with a colliding push, then writes disabled
      for (int i = 0; i < 5; i++) cyc(1'b1, 9'(9'h0D0 + i), 1'b0);
      cyc(1'b1, 9'h1F0, 1'b0, 1'b1);
      chk("t5_level",   {27'd0, level},         32'd0);
      chk("t5_out_vld", {31'd0, bus.out_vld_o}, 32'd0);
      fifo_en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, 9'(9'h0E0 + i), 1'b0);
         chk("t5_in_rdy", {31'd0, bus.in_rdy_o}, 32'd0);
      end
      chk("t5_dis_level",   {27'd0, level},   32'd0);
      chk("t5_dis_overrun", {31'd0, overrun}, 32'd0);
      fifo_en = 1'b1;

      // 6: stream with pop gaps across the wrap, async reset mid-stream
      cnt = 0;
      k   = 0;
      while (cnt < 25) begin
         if (k % 4 != 3) begin
            cyc(1'b1, 9'(cnt * 7 + 3), (k % 3 != 0));
            cnt++;
         end else begin
            cyc(1'b0, 9'h000, (k % 3 != 0));
         end
         k++;
      end
      bus.out_rdy_i = 1'b0;
      #2 rst = 1'b1;
      #1 check_reset("mid_rst");
      sb.delete();
      ovr_m = 1'b0;
      #3 rst = 1'b0;
      @(posedge clk);
      #1;
      cyc(1'b1, 9'h0C3, 1'b0);
      chk("t6_c3_dat",   {23'd0, bus.out_dat_o}, 32'h0C3);
      chk("t6_c3_level", {27'd0, level},         32'd1);
      k = 0;
      while (cnt < 40) begin
         if (k % 4 != 3) begin
            cyc(1'b1, 9'(cnt * 7 + 3), (k % 3 != 0));
            cnt++;
         end else begin
            cyc(1'b0, 9'h000, (k % 3 != 0));
         end
         k++;
      end
      drain();
      chk("sb_empty", sb.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/prmcu_uart_rx_fifo.md
Name: prmcu_uart_rx_fifo

Overview:
Receive buffer directly downstream of the UART receiver. It consumes the receiver's out_dat/out_vld/out_rdy stream and stores received 9-bit words (data plus optional 9th/parity bit, stored unchanged) in a first-word-fall-through FIFO. It presents them to the bus-side reader with level, threshold-interrupt and sticky-overrun status. The UART receiver cannot stall the line, so the FIFO never back-pressures while enabled; it drops words on full and flags the loss.

Parameters:
DATA_W, 9, stored word width (matches the UART data port).
DEPTH, 16, number of entries; power of two, minimum 2.
ADDR_W, $clog2(DEPTH), pointer width (derived; not overridden).

Ports:
clk  in  1  system clock (10 MHz nominal).
rst  in  1  reset; asynchronous, active-high.
fifo_en_i  in  1  enable write side; 0 = ignore incoming words.
flush_i  in  1  synchronous clear of contents and overrun.
in_dat_i  in  DATA_W  word from the UART receiver.
in_vld_i  in  1  word valid from the receiver.
in_rdy_o  out  1  ready to the receiver; equals fifo_en_i.
out_dat_o  out  DATA_W  head-of-FIFO word.
out_vld_o  out  1  FIFO non-empty.
out_rdy_i  in  1  reader pop strobe; pop when out_vld_o & out_rdy_i.
level_o  out  ADDR_W+1  current occupancy, 0..DEPTH.
threshold_i  in  ADDR_W+1  interrupt threshold; 0 disables.
thr_irq_o  out  1  registered, level_o >= threshold_i and threshold_i != 0.
full_o  out  1  level_o == DEPTH.
empty_o  out  1  level_o == 0.
overrun_o  out  1  sticky: a word was dropped on full.
overrun_clr_i  in  1  clears overrun_o.

Behaviour:
- Reset: pointers 0, level_o 0, out_vld_o 0, empty_o 1, full_o 0, thr_irq_o 0, overrun_o 0. The stored array is not reset. out_dat_o is undefined while out_vld_o is 0.
- Pointers: wr_ptr and rd_ptr are ADDR_W+1 bits, with the MSB as the wrap bit. Empty when the pointers are equal. Full when the low bits are equal and the MSBs differ. level_o = wr_ptr - rd_ptr, modulo 2^(ADDR_W+1).
- Push: in_vld_i & fifo_en_i & (!full | pop in the same cycle). The word is written at wr_ptr and wr_ptr increments.
- Push latency: a word pushed at edge N gives out_vld_o = 1 and a valid out_dat_o after edge N, i.e. in cycle N+1. FWFT: out_dat_o = mem[rd_ptr] with combinational read.
- Pop: out_vld_o & out_rdy_i. rd_ptr increments. out_rdy_i while empty has no effect.
- Simultaneous push+pop when full: both happen, level stays DEPTH, no overrun.
- Simultaneous push+pop when empty: push only. Pop is impossible because out_vld_o is 0.
- Drop: in_vld_i & fifo_en_i & full & !pop. The word is discarded, overrun_o is set on the next edge, and FIFO contents are unchanged.
- fifo_en_i = 0: in_rdy_o = 0, in_vld_i is ignored, no overrun is raised, and the read side keeps draining normally.
- flush_i: highest priority among synchronous events. Both pointers go to 0, overrun_o goes to 0, and any same-cycle push or pop is discarded. After the edge: out_vld_o 0, level_o 0.
- Overrun priority: set > clr when both occur in the same cycle, so no event is lost.
- thr_irq_o: registered from next-state level, so it asserts on the same edge the level reaches threshold_i. It drops on the edge the level falls below threshold_i.
- Wrap-around: pointers roll over naturally, and data order is preserved across the DEPTH boundary.
- Reset mid-operation: all state clears immediately (async). On deassertion the FIFO is empty, with no spurious out_vld_o.

Decomposition:
- prmcu_uart_pkg gets the UART_DATA_W = 9 constant, the default RX FIFO depth constant, and a typedef for the 9-bit UART word.
- Sub-module prmcu_fifo_mem: DEPTH x DATA_W register array with one synchronous write port and one combinational read port, no reset. All pointer, flag and status logic stays in prmcu_uart_rx_fifo.

Test Plan:
1. Fill/drain: DEPTH=16, threshold 0, push 0x000..0x00F back-to-back, then pop all with out_rdy_i=1. Expect: out_vld_o high 1 cycle after the first push; full_o at level 16; words 0x000..0x00F popped in order; empty_o=1 at the end; overrun_o=0.
2. Overrun: fill 16, push 0x1AA with no pop. Expect overrun_o=1 next cycle and level_o=16; popping all returns the original 16 words and never 0x1AA. Pulse overrun_clr_i, expect overrun_o=0.
3. Full push+pop: when full, push 0x155 with out_rdy_i=1 in the same cycle. Expect level_o stays 16, overrun_o=0, and 0x155 is the last word drained.
4. Threshold: threshold_i=4, push 4 words. Expect thr_irq_o=1 on the 4th push edge; one pop gives thr_irq_o=0 on that edge. With threshold_i=0, thr_irq_o is never asserted.
5. Flush/enable: push 5 words, assert flush_i together with a push. Expect level_o=0 and out_vld_o=0, with the pushed word lost. Then set fifo_en_i=0 and drive in_vld_i for 3 words: expect in_rdy_o=0, level_o=0, overrun_o=0.
6. Wrap plus async reset: stream 40 words through with random pop gaps, checking order against a scoreboard. Assert rst mid-stream (not on a clk edge): expect all outputs at reset values immediately; after release, the new word 0x0C3 is received correctly.
